// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first payload, optional even/odd parity, stop bit.
// Each bit lasts Prescale clocks. TX_OUT and busy come straight from flops.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_n;
  logic [4:0]            edge_cnt, edge_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q;
  logic [5:0]            presc_q;
  logic                  accept, bit_end, legal;
  logic                  tx_n, busy_n, data_bit, parity_bit;

  assign legal      = (Prescale == 6'd4) || (Prescale == 6'd8) ||
                      (Prescale == 6'd16) || (Prescale == 6'd32);
  assign bit_end    = ({1'b0, edge_cnt} == (presc_q - 6'd1));
  assign parity_bit = (^data_q) ^ par_typ_q;

  always_comb begin
    state_n = state;
    edge_n  = edge_cnt;
    bit_n   = bit_cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (Data_Valid && legal) begin
          accept  = 1'b1;
          state_n = START;
          edge_n  = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          edge_n  = '0;
        end else begin
          edge_n = edge_cnt + 5'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          edge_n = '0;
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            bit_n   = '0;
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end else begin
          edge_n = edge_cnt + 5'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          edge_n  = '0;
        end else begin
          edge_n = edge_cnt + 5'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          edge_n  = '0;
        end else begin
          edge_n = edge_cnt + 5'd1;
        end
      end
      default: begin
        state_n = IDLE;
        edge_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Line value is decoded from the next state so the registered output lines up with it.
  always_comb begin
    data_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (bit_n == BW'(i)) data_bit = data_q[i];
    end
  end

  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_bit;
      PARITY:  tx_n = parity_bit;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state    <= state_n;
      edge_cnt <= edge_n;
      bit_cnt  <= bit_n;
      TX_OUT   <= tx_n;
      busy     <= busy_n;
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        presc_q   <= Prescale;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer; expected line values come from a
// frame model built from the protocol rules (bit index = cycle / prescale).
module tb_uart_tx_serializer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [5:0]    Prescale = 6'd8;
  logic          TX_OUT, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  function automatic int unsigned frame_len(input logic pen, input int unsigned p);
    return p * (DW + 2 + (pen ? 1 : 0));
  endfunction

  // Expected line value k clocks after the frame's first (start) cycle.
  function automatic logic exp_tx(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                                  input int unsigned p, input int unsigned k);
    int unsigned b;
    b = k / p;
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (pen && b == DW + 1) return (($countones(d) % 2) == 1) ^ ptyp;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_async tx=%b busy=%b expected tx=1 busy=0", TX_OUT, busy);
    end
    Data_Valid = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold tx=%b busy=%b expected tx=1 busy=0", TX_OUT, busy);
      end
    end
    Data_Valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [9:0] seq;
    seq = 10'b1101001010;
    Prescale = 6'd8; PAR_EN = 1'b0; P_DATA = 8'hA5; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      checks++;
      if (TX_OUT !== seq[k/8] || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_a5 k=%0d tx=%b busy=%b expected tx=%b busy=1", k, TX_OUT, busy, seq[k/8]);
      end
      step();
    end
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end tx=%b busy=%b expected tx=1 busy=0", TX_OUT, busy);
    end
    repeat (3) step();
  endtask

  task automatic test_parity();
    for (int t = 0; t < 2; t++) begin
      Prescale = 6'd4; PAR_EN = 1'b1; PAR_TYP = t[0]; P_DATA = 8'h07; Data_Valid = 1'b1;
      step();
      Data_Valid = 1'b0;
      for (int k = 0; k < 44; k++) begin
        checks++;
        if (TX_OUT !== exp_tx(8'h07, 1'b1, t[0], 4, k) || busy !== 1'b1) begin
          failures++;
          $display("FAIL parity typ=%0d k=%0d tx=%b busy=%b expected tx=%b busy=1",
                   t, k, TX_OUT, busy, exp_tx(8'h07, 1'b1, t[0], 4, k));
        end
        if (k == 37) begin
          checks++;
          if (TX_OUT !== (t == 0 ? 1'b1 : 1'b0)) begin
            failures++;
            $display("FAIL parity_bit typ=%0d got=%b expected=%b", t, TX_OUT, (t == 0));
          end
        end
        step();
      end
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL parity_end typ=%0d tx=%b busy=%b expected tx=1 busy=0", t, TX_OUT, busy);
      end
      repeat (2) step();
    end
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
  endtask

  task automatic test_hold_dv();
    Prescale = 6'd32; PAR_EN = 1'b0; P_DATA = 8'h3C; Data_Valid = 1'b1;
    step();
    for (int k = 0; k < 320; k++) begin
      checks++;
      if (TX_OUT !== exp_tx(8'h3C, 1'b0, 1'b0, 32, k) || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_first k=%0d tx=%b busy=%b expected tx=%b busy=1",
                 k, TX_OUT, busy, exp_tx(8'h3C, 1'b0, 1'b0, 32, k));
      end
      if (k == 100) P_DATA = 8'hFF;
      step();
    end
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_gap tx=%b busy=%b expected tx=1 busy=0", TX_OUT, busy);
    end
    step();
    for (int k = 0; k < 320; k++) begin
      checks++;
      if (TX_OUT !== exp_tx(8'hFF, 1'b0, 1'b0, 32, k) || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_second k=%0d tx=%b busy=%b expected tx=%b busy=1",
                 k, TX_OUT, busy, exp_tx(8'hFF, 1'b0, 1'b0, 32, k));
      end
      if (k == 10) Data_Valid = 1'b0;
      step();
    end
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_end tx=%b busy=%b expected tx=1 busy=0", TX_OUT, busy);
    end
    repeat (3) step();
  endtask

  task automatic test_illegal_prescale();
    logic [5:0] p;
    Prescale = 6'd12; P_DATA = 8'h81; Data_Valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL illegal_p12 k=%0d tx=%b busy=%b expected tx=1 busy=0", k, TX_OUT, busy);
      end
    end
    for (int i = 0; i < 8; i++) begin
      do p = 6'($urandom_range(0, 63));
      while (p == 6'd4 || p == 6'd8 || p == 6'd16 || p == 6'd32);
      Prescale = p;
      repeat (4) begin
        step();
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL illegal_rand p=%0d tx=%b busy=%b expected tx=1 busy=0", p, TX_OUT, busy);
        end
      end
    end
    Data_Valid = 1'b0; Prescale = 6'd8;
    step();
  endtask

  task automatic test_ignore_dv();
    Prescale = 6'd8; PAR_EN = 1'b0; P_DATA = 8'h5A; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      checks++;
      if (TX_OUT !== exp_tx(8'h5A, 1'b0, 1'b0, 8, k) || busy !== 1'b1) begin
        failures++;
        $display("FAIL ignore_frame k=%0d tx=%b busy=%b expected tx=%b busy=1",
                 k, TX_OUT, busy, exp_tx(8'h5A, 1'b0, 1'b0, 8, k));
      end
      Data_Valid = (k == 3 || k == 30 || k == 75);
      P_DATA = Data_Valid ? 8'hC3 : 8'h5A;
      step();
    end
    Data_Valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL ignore_idle k=%0d tx=%b busy=%b expected tx=1 busy=0", k, TX_OUT, busy);
      end
      step();
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] d;
    d = DW'($urandom);
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1; P_DATA = d; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    for (int k = 0; k < 70; k++) begin
      checks++;
      if (TX_OUT !== exp_tx(d, 1'b1, 1'b1, 16, k) || busy !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_pre k=%0d tx=%b busy=%b expected tx=%b busy=1",
                 k, TX_OUT, busy, exp_tx(d, 1'b1, 1'b1, 16, k));
      end
      step();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async tx=%b busy=%b expected tx=1 busy=0", TX_OUT, busy);
    end
    step();
    step();
    @(negedge clk) rst = 1'b1;
    step();
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_noresume k=%0d tx=%b busy=%b expected tx=1 busy=0", k, TX_OUT, busy);
      end
      step();
    end
    d = DW'($urandom);
    PAR_EN = 1'b0; P_DATA = d; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    for (int k = 0; k <= 160; k++) begin
      checks++;
      if (TX_OUT !== exp_tx(d, 1'b0, 1'b1, 16, k) || busy !== (k < 160)) begin
        failures++;
        $display("FAIL rstmid_fresh k=%0d tx=%b busy=%b expected tx=%b busy=%b",
                 k, TX_OUT, busy, exp_tx(d, 1'b0, 1'b1, 16, k), (k < 160));
      end
      step();
    end
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] d;
    logic          pen, ptyp;
    int unsigned   p, len;
    for (int f = 0; f < 20; f++) begin
      d = DW'($urandom); pen = 1'($urandom); ptyp = 1'($urandom);
      p = 4 << $urandom_range(0, 3);
      len = frame_len(pen, p);
      P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Prescale = 6'(p); Data_Valid = 1'b1;
      step();
      Data_Valid = 1'b0;
      for (int unsigned k = 0; k <= len; k++) begin
        checks++;
        if (TX_OUT !== exp_tx(d, pen, ptyp, p, k) || busy !== (k < len)) begin
          failures++;
          $display("FAIL random f=%0d d=%h p=%0d pen=%b typ=%b k=%0d tx=%b busy=%b expected tx=%b busy=%b",
                   f, d, p, pen, ptyp, k, TX_OUT, busy, exp_tx(d, pen, ptyp, p, k), (k < len));
        end
        P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        Prescale = 6'($urandom);
        step();
      end
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_hold_dv();
    test_illegal_prescale();
    test_ignore_dv();
    test_reset_midframe();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload, sampled at acceptance.
REQ-005 SHALL have port Data_Valid  input  1  request to send P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  1 = insert parity bit after data.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port Prescale  input  6  clocks per bit; legal values 4, 8, 16, 32.
REQ-009 SHALL have port TX_OUT  output  1  serial line, registered, idles high.
REQ-010 SHALL have port busy  output  1  high while a frame is on the line, registered.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL accept a frame on a rising edge where state=IDLE, Data_Valid=1 and Prescale is legal; Data_Valid in any other state is ignored, with no queueing.
REQ-013 SHALL ignore Data_Valid in IDLE when Prescale is not 4/8/16/32; TX_OUT stays 1 and busy stays 0.
REQ-014 SHALL latch P_DATA, PAR_EN, PAR_TYP and Prescale at acceptance; input changes mid-frame have no effect on the frame.
REQ-015 SHALL enter START on the cycle after acceptance, with TX_OUT=0 and busy=1 on that same cycle (latency 1 clock).
REQ-016 SHALL hold each bit on TX_OUT for exactly P clocks (P = latched Prescale), using an edge counter that runs 0..P-1 and wraps to 0 at each bit boundary.
REQ-017 SHALL send data LSB first in DATA, using a bit counter from 0 to DATA_WIDTH-1.
REQ-018 SHALL send the PARITY state only when latched PAR_EN=1, with bit = XOR of data for even parity and XNOR of data for odd parity; PAR_EN=0 goes DATA->STOP.
REQ-019 SHALL drive TX_OUT=1 for P clocks in STOP, then return to IDLE with busy=0 and TX_OUT=1.
REQ-020 SHALL keep busy high for exactly P*(DATA_WIDTH+2) clocks, or P*(DATA_WIDTH+3) with parity.
REQ-021 SHALL accept a new frame no earlier than the first IDLE cycle, so at least one idle-high clock separates frames when Data_Valid is held high.
REQ-022 SHALL keep counters sized for P=32 (edge 5 bits, bit ceil(log2(DATA_WIDTH+1))) with no overflow at P=32.
REQ-023 SHALL produce TX_OUT only from flops, with no combinational path from inputs to TX_OUT or busy.

Reset
REQ-024 SHALL, when rst=0, immediately force state=IDLE, TX_OUT=1, busy=0, all counters 0 and latched registers 0, regardless of clk.
REQ-025 SHALL abort a frame in progress when reset is asserted mid-frame; TX_OUT goes high at once and no partial frame resumes after release.
REQ-026 SHALL, after rst deasserts, accept a frame only on a rising edge at which rst is already 1.

Verification
REQ-027 SHALL cover: Prescale=8, PAR_EN=0, P_DATA=8'hA5, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 with each bit 8 clocks; busy high 80 clocks.
REQ-028 SHALL cover: Prescale=4, PAR_EN=1, PAR_TYP=0, P_DATA=8'h07 -> parity bit 1; PAR_TYP=1 on the same data -> parity bit 0; busy high 44 clocks.
REQ-029 SHALL cover: Prescale=32, Data_Valid held high, P_DATA changed to 8'hFF mid-frame -> first frame carries the original data; exactly 1 idle-high clock; second frame carries 8'hFF.
REQ-030 SHALL cover: Prescale=6'd12 with Data_Valid=1 for 50 clocks -> TX_OUT=1 and busy=0 throughout.
REQ-031 SHALL cover: rst pulsed low during data bit 3 of a Prescale=16 frame -> TX_OUT=1 and busy=0 asynchronously; a fresh frame after release is bit-exact.
REQ-032 SHALL cover: Data_Valid pulses during START, DATA and STOP -> ignored; only the first frame is transmitted.
